poly_pointwise_mont_ctrl: RTL

//  Sequences a coefficient-wise Montgomery multiply over two N-coefficient polynomials (ML-KEM, FIPS 203).

---
 rtl/poly_pointwise_mont_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/poly_pointwise_mont_ctrl.sv
// rtl/poly_pointwise_mont_ctrl.sv - coefficient-wise Montgomery multiply sequencer (ML-KEM)
//
// Streams a[i], b[i] out of two sync-read RAMs, forms the signed 32-bit
// product, hands it to the external combinational Montgomery reducer and
// writes r[i] = a[i]*b[i]*2^-16 mod Q back to the result RAM.
// One coefficient per cycle; one job per accepted start pulse.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   start_i                   job request, sampled only while idle
//   busy_o, done_o            job in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_o        shared read port for the A and B RAMs
//   a_data_i, b_data_i        RAM read data, one cycle after rd_en_o
//   red_z_o, red_res_i        product to the reducer / its reduced result
//   wr_en_o, wr_addr_o,
//   wr_data_o                 result RAM write port
module poly_pointwise_mont_ctrl #(
  parameter int N       = 256,
  parameter int COEFF_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rd_en_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  input  logic signed [COEFF_W-1:0] a_data_i,
  input  logic signed [COEFF_W-1:0] b_data_i,
  output logic signed [31:0]        red_z_o,
  input  logic signed [COEFF_W-1:0] red_res_i,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic signed [COEFF_W-1:0] wr_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  state_t              state_q;
  logic                drain_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;

  // Two-stage valid/address shift: stage 1 = RAM data cycle, stage 2 = write cycle.
  logic                v1_q;
  logic [ADDR_W-1:0]   addr1_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic signed [31:0]  prod_q;

  logic signed [31:0]  a_ext;
  logic signed [31:0]  b_ext;

  assign a_ext = {{(32-COEFF_W){a_data_i[COEFF_W-1]}}, a_data_i};
  assign b_ext = {{(32-COEFF_W){b_data_i[COEFF_W-1]}}, b_data_i};

  // Sequencer. rd_addr_q doubles as the element counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        RUN: begin
          if (rd_addr_q == LAST_IDX) begin
            state_q     <= DRAIN;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            drain_cnt_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // Two cycles: last index is in the multiply stage, then in the write stage.
          if (drain_cnt_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        DONE: begin
          // start_i is deliberately not looked at here; IDLE re-samples it.
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath pipeline. prod_q only loads on valid data so red_z_o holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      addr1_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      prod_q    <= '0;
    end else begin
      v1_q      <= rd_en_q;
      addr1_q   <= rd_addr_q;
      wr_en_q   <= v1_q;
      wr_addr_q <= addr1_q;
      if (v1_q) begin
        prod_q <= a_ext * b_ext;
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign red_z_o   = prod_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = red_res_i;

endmodule
